// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with PC, imem handshake and sticky fault
//
// Owns the program counter, fetches one 32-bit word per instruction over a
// req/ack handshake and holds it (with decoded opcode/funct3/funct7b5) until
// execute retires it. A misaligned next PC or an imem timeout parks the unit
// in FAULT until reset.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request and address (address == pc)
//   imem_ack/imem_rdata      memory response, sampled only while requesting
//   instr_valid, instr       held instruction word and its valid flag
//   opcode/funct3/funct7b5   decoded fields of the held instruction
//   pc, pc_plus4             address of held/pending instruction and pc + 4
//   instr_done               execute retires the held instruction
//   PC_sel, pc_target        next-PC select (1 = target) and branch/jump target
//   fetch_fault              sticky fault indicator
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        PC_sel,
    input  logic [31:0] pc_target,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    // run_q is low only in the cycle right after reset, so imem_req stays low
    // while reset is held and rises one cycle after reset is released.
    logic        run_q, run_d;
    logic [31:0] next_pc;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            cnt_q   <= 8'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        run_d   = 1'b1;
        next_pc = PC_sel ? pc_target : pc_inc;

        case (state_q)
            FETCH: begin
                if (run_q) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        cnt_d   = 8'd0;
                        state_d = HOLD;
                    end else if (cnt_q == TIMEOUT_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (instr_done) begin
                    // No masking of low bits: a misaligned target is an error
                    // and the last legal pc is kept for diagnosis.
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        cnt_d   = 8'd0;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH) && run_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign fetch_fault = (state_q == FAULT);
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign pc          = pc_q;
    assign pc_plus4    = pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with behavioural reference model
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_done = 1'b0;
    logic        PC_sel = 1'b0;
    logic [31:0] pc_target = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr_done(instr_done), .PC_sel(PC_sel), .pc_target(pc_target),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mem_wait = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // Memory responder: acks after a configurable number of wait cycles
    // (negative = never), garbage data on non-ack cycles.
    int rcnt = 0;
    int rwait = 0;
    always @(negedge clk) begin
        if (!imem_req) begin
            rcnt       = 0;
            rwait      = int'($urandom_range(0, 5));
            imem_ack   = rand_mode ? 1'($urandom) : 1'b0;
            imem_rdata = $urandom;
        end else begin
            int w;
            w          = rand_mode ? rwait : mem_wait;
            imem_ack   = (w >= 0) && (rcnt == w);
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
            rcnt++;
        end
    end

    // Reference model: phases of one fetch/execute lifecycle.
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_HAVE = 2, PH_DEAD = 3;
    int          ph = PH_IDLE;
    int          waited = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = NOP;
    bit          live = 1'b0;
    logic [32:0] nxt;

    always @(posedge clk) begin
        if (reset) begin
            live = 1'b1; ph = PH_IDLE; m_pc = RST_PC; m_instr = NOP; waited = 0;
        end else if (live) begin
            case (ph)
                PH_IDLE: begin ph = PH_REQ; waited = 0; end
                PH_REQ: begin
                    if (imem_ack) begin m_instr = imem_rdata; ph = PH_HAVE; end
                    else if (waited == TO) ph = PH_DEAD;
                    else waited++;
                end
                PH_HAVE: begin
                    if (instr_done) begin
                        nxt = PC_sel ? {1'b0, pc_target}
                                     : ({1'b0, m_pc} + 33'd4) % 33'h1_0000_0000;
                        if (nxt % 4 != 0) ph = PH_DEAD;
                        else begin m_pc = nxt[31:0]; ph = PH_REQ; waited = 0; end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("req",      32'(imem_req),    32'(ph == PH_REQ));
            chk("addr",     imem_addr,        m_pc);
            chk("valid",    32'(instr_valid), 32'(ph == PH_HAVE));
            chk("fault",    32'(fetch_fault), 32'(ph == PH_DEAD));
            chk("instr",    instr,            m_instr);
            chk("opcode",   32'(opcode),      m_instr % 128);
            chk("funct3",   32'(funct3),      (m_instr / 4096) % 8);
            chk("funct7b5", 32'(funct7b5),    (m_instr >> 30) & 1);
            chk("pc",       pc,               m_pc);
            chk("pc_plus4", pc_plus4,         m_pc + 32'd4);
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin @(negedge clk); n++; end
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic retire(input logic sel, input logic [31:0] tgt);
        wait_valid();
        instr_done = 1'b1; PC_sel = sel; pc_target = tgt;
        @(negedge clk);
        instr_done = 1'b0; PC_sel = 1'($urandom); pc_target = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        mem_wait = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_instr", instr, 32'h0050_0093);
        chk("c2_opcode", 32'(opcode), 32'h13);
        chk("c2_funct3", 32'(funct3), 32'd0);
        chk("c2_funct7b5", 32'(funct7b5), 32'd0);
        chk("c2_pc", pc, 32'h0);

        for (int i = 1; i <= 4; i++) begin
            retire(1'b0, 32'hDEAD_BEE0);
            chk("seq_addr", imem_addr, 32'(4 * i));
            @(negedge clk);
            chk("seq_2cyc", 32'(instr_valid), 32'd1);
        end

        PC_sel = 1'b1; pc_target = 32'h100; instr_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("nodone_pc", pc, 32'h10);
        chk("nodone_valid", 32'(instr_valid), 32'd1);
        retire(1'b1, 32'h100);
        chk("br_addr", imem_addr, 32'h100);

        wait_valid();
        mem_wait = 3;
        retire(1'b1, 32'h8);
        for (int k = 0; k < 4; k++) begin
            chk("ws_addr", imem_addr, 32'h8);
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        chk("ws_valid_after", 32'(instr_valid), 32'd1);
        chk("ws_instr", instr, mem_word(32'h8));

        mem_wait = -1;
        retire(1'b0, 32'h0);
        chk("to_rise", 32'(imem_req), 32'd1);
        repeat (4) @(negedge clk);
        chk("to_k4_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        chk("to_k5_fault", 32'(fetch_fault), 32'd1);
        chk("to_k5_req", 32'(imem_req), 32'd0);
        chk("to_k5_pc", pc, 32'hC);

        mem_wait = 0;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("rst2_pc", pc, RST_PC);
        chk("rst2_fault", 32'(fetch_fault), 32'd0);

        retire(1'b1, 32'h102);
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("rst3_fault", 32'(fetch_fault), 32'd0);
        chk("rst3_pc", pc, RST_PC);

        retire(1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid();
        chk("wrap_plus4", pc_plus4, 32'h0);
        retire(1'b0, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);
        chk("wrap_fault", 32'(fetch_fault), 32'd0);

        retire(1'b1, 32'h40);
        chk("mid_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_instr", instr, NOP);
        chk("mid_pc", pc, RST_PC);
        chk("mid_valid", 32'(instr_valid), 32'd0);

        rand_mode = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            instr_done = ($urandom % 3) == 0;
            PC_sel     = 1'($urandom);
            pc_target  = (($urandom % 16) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            reset      = fetch_fault ? (($urandom % 3) == 0) : (($urandom % 400) == 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
